// File: rtl/iic_pkg.sv
// ---------------------------------------------------------------------------
// iic_pkg
// Shared definitions for the IIC EEPROM slave:
//   - iic_state_e      : byte-level protocol FSM states
//   - DEV_ID_DEFAULT   : default upper nibble of the 7-bit device address
//   - IIC_BITS         : clocks per IIC byte transfer (8 data + 1 ACK)
//   - BYTE_DONE        : bit-counter value once all 8 data bits are sampled
//   - dev_match()      : compares a received address byte against the device
// ---------------------------------------------------------------------------
package iic_pkg;

   typedef enum logic [3:0] {
      IDLE,
      DEV_ADDR,
      DEV_ACK,
      WORD_ADDR,
      WA_ACK,
      WR_DATA,
      WR_ACK,
      RD_DATA,
      RD_ACK
   } iic_state_e;

   localparam logic [3:0] DEV_ID_DEFAULT = 4'b1010;

   localparam int unsigned IIC_BITS  = 9;
   localparam int unsigned BIT_CNT_W = $clog2(IIC_BITS + 1);

   // The counter counts sampled rising edges, so it holds 8 on the falling
   // edge that ends the last data bit of a byte.
   localparam logic [BIT_CNT_W-1:0] BYTE_DONE = BIT_CNT_W'(IIC_BITS - 1);

   // Upper seven bits of the address byte against {id, a2, a1, a0};
   // bit 0 is the R/W flag and does not take part in the match.
   function automatic logic dev_match(input logic [7:0] addr_byte,
                                      input logic [3:0] id,
                                      input logic [2:0] straps);
      return addr_byte[7:1] == {id, straps};
   endfunction

endpackage

// File: rtl/iic_bus_sync.sv
// ---------------------------------------------------------------------------
// iic_bus_sync
// Two-flop synchronizers for SCL and SDA plus edge / START / STOP detection,
// all derived from the synchronized values.
// Ports:
//   clk, reset_n   : system clock, async active-low reset
//   scl, sda       : raw bus lines from the pads
//   sda_s          : synchronized SDA
//   scl_rise/fall  : one-cycle pulses on synchronized SCL edges
//   start_det      : one-cycle pulse, SDA fell while SCL high
//   stop_det       : one-cycle pulse, SDA rose while SCL high
// ---------------------------------------------------------------------------
module iic_bus_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic scl,
   input  logic sda,
   output logic sda_s,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   logic scl_m, scl_s, scl_d;
   logic sda_m, sda_d;

   // Reset to 1 so a released reset looks like an idle bus, not an edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scl_m <= 1'b1;
         scl_s <= 1'b1;
         scl_d <= 1'b1;
         sda_m <= 1'b1;
         sda_s <= 1'b1;
         sda_d <= 1'b1;
      end else begin
         scl_m <= scl;
         scl_s <= scl_m;
         scl_d <= scl_s;
         sda_m <= sda;
         sda_s <= sda_m;
         sda_d <= sda_s;
      end
   end

   always_comb begin
      scl_rise  =  scl_s & ~scl_d;
      scl_fall  = ~scl_s &  scl_d;
      // SCL must be high on both samples so an SDA change that coincides
      // with an SCL edge is not mistaken for a bus condition.
      start_det =  scl_s &  scl_d &  sda_d & ~sda_s;
      stop_det  =  scl_s &  scl_d & ~sda_d &  sda_s;
   end

endmodule

// File: rtl/iic_eeprom_slave.sv
// ---------------------------------------------------------------------------
// iic_eeprom_slave
// IIC serial EEPROM slave with an inferred 2**ADDR_W byte memory, page-wrap
// writes, full-wrap sequential reads, random read via repeated START and
// write protection.
// Parameters:
//   DEV_ID  : upper nibble of the 7-bit device address
//   ADDR_W  : word-address width (at most 8, one address byte is received)
//   PAGE_W  : page-offset width, writes wrap inside 2**PAGE_W bytes
// Ports:
//   clk      : system clock, at least 8x SCL
//   reset_n  : async active-low reset
//   scl, sdi : IIC clock and data as seen at the pads
//   a0..a2   : device-address straps
//   wp       : write protect, 1 blocks memory writes
//   sdo_oe   : open-drain pull-down enable for SDA
//   busy     : set on address match, cleared on STOP or START
// ---------------------------------------------------------------------------
module iic_eeprom_slave
   import iic_pkg::*;
#(
   parameter logic [3:0] DEV_ID = DEV_ID_DEFAULT,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned PAGE_W = 3
) (
   input  logic clk,
   input  logic reset_n,
   input  logic scl,
   input  logic sdi,
   input  logic a0,
   input  logic a1,
   input  logic a2,
   input  logic wp,
   output logic sdo_oe,
   output logic busy
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic sda_s, scl_rise, scl_fall, start_det, stop_det;

   iic_bus_sync u_bus_sync (
      .clk       (clk),
      .reset_n   (reset_n),
      .scl       (scl),
      .sda       (sdi),
      .sda_s     (sda_s),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   iic_state_e             state, state_nx;
   logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_nx;
   logic [ADDR_W-1:0]      ptr, ptr_nx;
   logic                   sdo_oe_nx, busy_nx;
   logic                   nack, nack_nx;
   logic                   wr_ok, wr_ok_nx;
   logic                   shift_en, tx_load, mem_we;

   logic [7:0]             shreg;
   logic [7:0]             tx;
   logic [7:0]             rd_q;
   logic [7:0]             mem [DEPTH];

   // Only the page-offset bits advance, so a burst stays inside its page.
   function automatic logic [ADDR_W-1:0] page_inc(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:PAGE_W], a[PAGE_W-1:0] + PAGE_W'(1)};
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         bit_cnt <= '0;
         ptr     <= '0;
         sdo_oe  <= 1'b0;
         busy    <= 1'b0;
         nack    <= 1'b0;
         wr_ok   <= 1'b0;
      end else begin
         state   <= state_nx;
         bit_cnt <= bit_cnt_nx;
         ptr     <= ptr_nx;
         sdo_oe  <= sdo_oe_nx;
         busy    <= busy_nx;
         nack    <= nack_nx;
         wr_ok   <= wr_ok_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      bit_cnt_nx = bit_cnt;
      ptr_nx     = ptr;
      sdo_oe_nx  = sdo_oe;
      busy_nx    = busy;
      nack_nx    = nack;
      wr_ok_nx   = wr_ok;
      shift_en   = 1'b0;
      tx_load    = 1'b0;
      mem_we     = 1'b0;

      if (stop_det) begin
         state_nx   = IDLE;
         bit_cnt_nx = '0;
         sdo_oe_nx  = 1'b0;
         busy_nx    = 1'b0;
      end else if (start_det) begin
         state_nx   = DEV_ADDR;
         bit_cnt_nx = '0;
         sdo_oe_nx  = 1'b0;
         busy_nx    = 1'b0;
      end else if (scl_rise) begin
         // Sampling edge: bits move into the device.
         case (state)
            DEV_ADDR, WORD_ADDR: begin
               shift_en   = 1'b1;
               bit_cnt_nx = bit_cnt + 1'b1;
            end
            WR_DATA: begin
               shift_en   = 1'b1;
               bit_cnt_nx = bit_cnt + 1'b1;
               if (bit_cnt == BYTE_DONE - 1'b1) begin
                  // Byte completes on this edge; wp is latched here so the
                  // ACK and pointer step agree with what was written.
                  mem_we   = ~wp;
                  wr_ok_nx = ~wp;
               end
            end
            RD_DATA: bit_cnt_nx = bit_cnt + 1'b1;
            RD_ACK:  nack_nx    = sda_s;
            default: ;
         endcase
      end else if (scl_fall) begin
         // Driving edge: SDA ownership and state changes happen here.
         case (state)
            DEV_ADDR: begin
               if (bit_cnt == BYTE_DONE) begin
                  bit_cnt_nx = '0;
                  if (dev_match(shreg, DEV_ID, {a2, a1, a0})) begin
                     state_nx  = DEV_ACK;
                     sdo_oe_nx = 1'b1;
                     busy_nx   = 1'b1;
                  end else begin
                     state_nx  = IDLE;
                     sdo_oe_nx = 1'b0;
                  end
               end
            end
            DEV_ACK: begin
               bit_cnt_nx = '0;
               // shreg still holds the address byte; bit 0 is R/W.
               if (shreg[0]) begin
                  state_nx  = RD_DATA;
                  tx_load   = 1'b1;
                  sdo_oe_nx = ~rd_q[7];
               end else begin
                  state_nx  = WORD_ADDR;
                  sdo_oe_nx = 1'b0;
               end
            end
            WORD_ADDR: begin
               if (bit_cnt == BYTE_DONE) begin
                  bit_cnt_nx = '0;
                  ptr_nx     = shreg[ADDR_W-1:0];
                  state_nx   = WA_ACK;
                  sdo_oe_nx  = 1'b1;
               end
            end
            WA_ACK: begin
               state_nx  = WR_DATA;
               sdo_oe_nx = 1'b0;
            end
            WR_DATA: begin
               if (bit_cnt == BYTE_DONE) begin
                  bit_cnt_nx = '0;
                  state_nx   = WR_ACK;
                  sdo_oe_nx  = wr_ok;
                  if (wr_ok) begin
                     ptr_nx = page_inc(ptr);
                  end
               end
            end
            WR_ACK: begin
               state_nx  = WR_DATA;
               sdo_oe_nx = 1'b0;
            end
            RD_DATA: begin
               if (bit_cnt == BYTE_DONE) begin
                  bit_cnt_nx = '0;
                  state_nx   = RD_ACK;
                  sdo_oe_nx  = 1'b0;
                  ptr_nx     = ptr + 1'b1;
               end else begin
                  // 7 - bit_cnt selects the next bit, MSB first.
                  sdo_oe_nx = ~tx[~bit_cnt[2:0]];
               end
            end
            RD_ACK: begin
               if (nack) begin
                  state_nx  = IDLE;
                  sdo_oe_nx = 1'b0;
               end else begin
                  state_nx  = RD_DATA;
                  tx_load   = 1'b1;
                  sdo_oe_nx = ~rd_q[7];
               end
            end
            default: ;
         endcase
      end
   end

   // Datapath registers carry no reset; the FSM decides when they matter.
   always_ff @(posedge clk) begin
      if (shift_en) begin
         shreg <= {shreg[6:0], sda_s};
      end
      if (tx_load) begin
         tx <= rd_q;
      end
   end

   // Registered read keeps one read and one write port; the pointer is
   // stable for many clocks before each byte is loaded.
   always_ff @(posedge clk) begin
      rd_q <= mem[ptr];
      if (mem_we) begin
         mem[ptr] <= {shreg[6:0], sda_s};
      end
   end

endmodule

// File: doc/iic_eeprom_slave.md
IIC_EEPROM_SLAVE -- requirements
Module: iic_eeprom_slave

Interface
REQ-001 Parameter DEV_ID, default 4'b1010: upper four bits of the 7-bit device address.
REQ-002 Parameter ADDR_W, default 8: word-address width; memory depth is 2**ADDR_W bytes.
REQ-003 Parameter PAGE_W, default 3: page-offset width; a page is 2**PAGE_W bytes.
REQ-004 clk  input  1  single system clock; SCL is oversampled on it, at least 8x the SCL rate.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 scl  input  1  IIC serial clock from the master.
REQ-007 sdi  input  1  IIC data line as seen at the pad.
REQ-008 a0, a1, a2  input  1 each  device-address select straps.
REQ-009 wp  input  1  write protect; 1 inhibits memory writes.
REQ-010 sdo_oe  output  1  open-drain pull-down enable; 1 drives SDA low, 0 releases SDA.
REQ-011 busy  output  1  1 from an accepted address match until the following STOP or START.

Function
REQ-012 scl and sdi SHALL each pass through a 2-flop synchronizer; all edge detection SHALL use the synchronized values.
REQ-013 START SHALL be detected as an sda falling edge while scl is high; STOP SHALL be detected as an sda rising edge while scl is high.
REQ-014 Bits SHALL be sampled on the synchronized scl rising edge; sdo_oe SHALL change only on the synchronized scl falling edge, or on STOP or START.
REQ-015 FSM states: IDLE, DEV_ADDR, DEV_ACK, WORD_ADDR, WA_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
REQ-016 A START SHALL move the FSM from any state to DEV_ADDR; a STOP SHALL move it from any state to IDLE with sdo_oe=0.
REQ-017 DEV_ADDR SHALL shift in 8 bits MSB first and SHALL match them against {DEV_ID, a2, a1, a0}.
REQ-018 On a match, DEV_ACK SHALL drive sdo_oe=1 for the 9th clock and then go to WORD_ADDR when R/W=0, or to RD_DATA when R/W=1.
REQ-019 On a mismatch, the FSM SHALL go to IDLE with sdo_oe=0 and no side effects.
REQ-020 WORD_ADDR SHALL load the ADDR_W-bit pointer and be ACKed unconditionally in WA_ACK, then go to WR_DATA.
REQ-021 WR_DATA SHALL shift in 8 bits; with wp=0 it SHALL write mem[pointer] at the 8th rising edge, ACK, and increment only the low PAGE_W bits of the pointer (page wrap).
REQ-022 With wp=1 a data byte SHALL NOT be written, SHALL be NACKed (sdo_oe=0), and the pointer SHALL stay unchanged.
REQ-023 RD_DATA SHALL drive mem[pointer] MSB first, with sdo_oe = ~bit.
REQ-024 After the 8th bit the pointer SHALL increment modulo 2**ADDR_W (full wrap).
REQ-025 In RD_ACK the master's sampled ACK (0) SHALL return the FSM to RD_DATA with the next byte, and a NACK (1) SHALL send it to IDLE.
REQ-026 A repeated START after WA_ACK SHALL keep the pointer, enabling a random read.
REQ-027 The pointer SHALL persist across transactions until reloaded by a write.
REQ-028 Memory contents SHALL NOT be cleared by reset.

Reset
REQ-029 With reset_n=0: FSM=IDLE, sdo_oe=0, busy=0, pointer=0, bit counter=0, synchronizer flops=1 (bus idle).
REQ-030 A reset mid-transaction SHALL release SDA within the same cycle (asynchronous), and no partial byte SHALL be written.

Structure
REQ-031 The state enum, DEV_ID default and the IIC bit-count constant (9) SHALL live in the shared package iic_pkg.
REQ-032 The synchronizer and edge/START/STOP detection SHALL form one sub-module, iic_bus_sync.
REQ-033 The memory SHALL be an inferred array with one write port and one read port.

Verification
REQ-034 Straps a2..a0=3'b001: write 0xA2, 0x10, 0x5A, STOP -> ACK on all three bytes; mem[0x10]=0x5A.
REQ-035 Random read: 0xA2, 0x10, repeated START, 0xA3, read one byte, NACK -> SDA carries 0x5A; FSM returns to IDLE.
REQ-036 Page wrap: write 0xA2, 0x0E, then data 0x01..0x04 -> mem[0x0E]=01, mem[0x0F]=02, mem[0x08]=03, mem[0x09]=04.
REQ-037 Address mismatch: send 0xA0 with straps 3'b001 -> SDA never driven low; busy stays 0.
REQ-038 wp=1: write 0xA2, 0x20, 0xFF -> device address and word address ACKed, data NACKed; mem[0x20] unchanged.
REQ-039 Reset pulsed during the 4th data bit of a write -> sdo_oe=0 immediately; FSM=IDLE; target byte unchanged.
